uart_tx: RTL and testbench

Memory-mapped UART transmitter peripheral on the SoC system bus, alongside the timer and DRAM. The CPU writes bytes through the bus; an internal FIFO buffers them; a bit-serial engine shifts them out on `tx` at a programmable baud divisor. A level interrupt to the CLINT signals that the transmitter has drained, and the serial line is what the SoC testbench monitors as console output.

---
 rtl/uart_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: bus registers, TX FIFO and 8N1 serial engine.
// Define UART_TX_PARITY_EN to add an even-parity bit gated by CTRL.pen.
module uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_we,
  input  logic [3:0]  uart_adr,
  input  logic [31:0] uart_wdata,
  output logic [31:0] uart_rdata,
  output logic        tx,
  output logic        int_sig
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t         state_q;
  logic           tx_q;
  logic [7:0]     shift_q;
  logic [2:0]     bit_idx_q;
  logic [15:0]    baud_q;
  logic [15:0]    div_lat_q;

  logic           en_q;
  logic           ien_q;
  logic [15:0]    div_q;
  logic           ovf_q;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

`ifdef UART_TX_PARITY_EN
  logic           pen_q;
  logic           pen_lat_q;
  logic           par_q;
`endif

  logic           wr_txdata, wr_status, wr_ctrl, wr_div;
  logic           fifo_empty, fifo_full;
  logic           busy;
  logic           pop, push;
  logic           baud_tc;
  logic [7:0]     head;
  logic [4:0]     cnt5;
  logic           pen_rd;
  logic           unused_bits;

  assign wr_txdata = uart_we && (uart_adr[3:2] == 2'd0);
  assign wr_status = uart_we && (uart_adr[3:2] == 2'd1);
  assign wr_ctrl   = uart_we && (uart_adr[3:2] == 2'd2);
  assign wr_div    = uart_we && (uart_adr[3:2] == 2'd3);

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign busy       = (state_q != S_IDLE);
  assign head       = mem_q[rd_ptr_q];

  // A push into a full FIFO still lands when the engine pops in the same cycle.
  assign pop  = (state_q == S_IDLE) && en_q && !fifo_empty;
  assign push = wr_txdata && (!fifo_full || pop);

  assign baud_tc = (baud_q == div_lat_q - 16'd1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (wr_txdata && fifo_full && !pop)
        ovf_q <= 1'b1;
      else if (wr_status && uart_wdata[3])
        ovf_q <= 1'b0;
    end
  end

  // FIFO storage carries data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= 1'b0;
      ien_q <= 1'b0;
      div_q <= DIV_RESET;
`ifdef UART_TX_PARITY_EN
      pen_q <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        en_q  <= uart_wdata[0];
        ien_q <= uart_wdata[1];
`ifdef UART_TX_PARITY_EN
        pen_q <= uart_wdata[2];
`endif
      end
      if (wr_div)
        div_q <= (uart_wdata[15:0] == 16'd0) ? 16'd1 : uart_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      div_lat_q <= 16'd1;
`ifdef UART_TX_PARITY_EN
      pen_lat_q <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      if (state_q != S_IDLE)
        baud_q <= baud_tc ? 16'd0 : baud_q + 16'd1;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q   <= head;
            div_lat_q <= div_q;
            baud_q    <= '0;
`ifdef UART_TX_PARITY_EN
            pen_lat_q <= pen_q;
            par_q     <= ^head;
`endif
            tx_q      <= 1'b0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (baud_tc) begin
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tc) begin
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (pen_lat_q) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_tc) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_tc) state_q <= S_IDLE;
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  assign pen_rd = pen_q;
`else
  assign pen_rd = 1'b0;
`endif

  assign cnt5 = 5'(cnt_q);

  always_comb begin
    uart_rdata = '0;
    case (uart_adr[3:2])
      2'd1:    uart_rdata = {23'd0, cnt5, ovf_q, fifo_empty, fifo_full, busy};
      2'd2:    uart_rdata = {29'd0, pen_rd, ien_q, en_q};
      2'd3:    uart_rdata = {16'd0, div_q};
      default: uart_rdata = '0;
    endcase
  end

  assign tx          = tx_q;
  assign int_sig     = ien_q & fifo_empty & ~busy;
  assign unused_bits = ^{uart_adr[1:0], uart_wdata[31:16]};

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed scenarios plus randomized bursts, checked against
// a byte-queue model that expands each byte into its expected serial frame.
module tb_uart_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_we;
  logic [3:0]  uart_adr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;
  logic        tx;
  logic        int_sig;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  exp_q[$];

  uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd10)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_we    (uart_we),
    .uart_adr   (uart_adr),
    .uart_wdata (uart_wdata),
    .uart_rdata (uart_rdata),
    .tx         (tx),
    .int_sig    (int_sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    uart_we = 1'b1; uart_adr = a; uart_wdata = d;
    cyc();
    uart_we = 1'b0; uart_adr = 4'h4;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    uart_adr = a;
    #1 d = uart_rdata;
    uart_adr = 4'h4;
  endtask

  // Serial frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    if (par) f[9] = ^b;
    return f;
  endfunction

  task automatic wait_low(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (tx !== 1'b0 && n < 2000);
    chk({tag, "_start"}, 32'(n), 32'(exp_n));
  endtask

  // Called at the first START cycle; returns in the last STOP cycle.
  // wr_at >= 0 clears CTRL (en=0) via a bus write issued at that frame cycle.
  task automatic frame(input string tag, input logic [7:0] b, input int div,
                       input bit par, input int wr_at);
    logic [10:0] f;
    logic        got;
    int          nb;
    int          k;
    f  = frame_bits(b, par);
    nb = par ? 11 : 10;
    k  = 0;
    for (int i = 0; i < nb; i++) begin
      got = f[i];
      for (int c = 0; c < div; c++) begin
        if (k > 0) cyc();
        if (tx !== f[i]) got = tx;
        if (k == wr_at) begin
          uart_we = 1'b1; uart_adr = 4'h8; uart_wdata = 32'h0;
        end else if (wr_at >= 0 && k == wr_at + 1) begin
          uart_we = 1'b0; uart_adr = 4'h4;
        end
        k++;
      end
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, got}, {31'd0, f[i]});
    end
  endtask

  task automatic drain(input string tag, input int div, input int first_n);
    logic [7:0] b;
    int         idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      wait_low($sformatf("%s%0d", tag, idx), (idx == 0) ? first_n : 2);
      frame($sformatf("%s%0d", tag, idx), b, div, 1'b0, -1);
      idx++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic        held;
    int          div, k;

    rst = 1'b1; uart_we = 1'b0; uart_adr = 4'h4; uart_wdata = '0;
    cyc(); cyc();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_int", {31'd0, int_sig}, 32'd0);
    rd(4'h4, d); chk("rst_status", d, 32'h004);
    cyc();
    rst = 1'b0;
    cyc();
    rd(4'h0, d); chk("txdata_rd", d, 32'h0);
    rd(4'h4, d); chk("status_init", d, 32'h004);
    rd(4'h8, d); chk("ctrl_init", d, 32'h0);
    rd(4'hC, d); chk("div_init", d, 32'd10);
    chk("idle_tx", {31'd0, tx}, 32'd1);

    // Basic frame
    wr(4'hC, 32'd4);
    wr(4'h8, 32'd1);
    wr(4'h0, 32'h55);
    wait_low("basic", 1);
    frame("basic", 8'h55, 4, 1'b0, -1);
    rd(4'h4, d); chk("basic_busy_stop", d, 32'h005);
    cyc();
    rd(4'h4, d); chk("basic_idle", d, 32'h004);

    // Back-to-back frames, count 1,2,1,0
    wr(4'h8, 32'd0);
    wr(4'hC, 32'd2);
    wr(4'h0, 32'hA5);
    rd(4'h4, d); chk("b2b_cnt1", d, 32'h010);
    wr(4'h0, 32'h3C);
    rd(4'h4, d); chk("b2b_cnt2", d, 32'h020);
    wr(4'h8, 32'd1);
    wait_low("b2b0", 1);
    rd(4'h4, d); chk("b2b_cnt1b", d, 32'h011);
    frame("b2b0", 8'hA5, 2, 1'b0, -1);
    wait_low("b2b1", 2);
    rd(4'h4, d); chk("b2b_cnt0", d, 32'h005);
    frame("b2b1", 8'h3C, 2, 1'b0, -1);
    cyc();
    rd(4'h4, d); chk("b2b_idle", d, 32'h004);

    // Overflow
    wr(4'h8, 32'd0);
    wr(4'hC, 32'd3);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      wr(4'h0, {24'd0, b});
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
    end
    rd(4'h4, d); chk("ovf_status", d, 32'h08A);
    wr(4'h4, 32'h8);
    rd(4'h4, d); chk("ovf_clr", d, 32'h082);
    wr(4'h8, 32'd1);
    drain("ovf", 3, 1);
    cyc();
    rd(4'h4, d); chk("ovf_drained", d, 32'h004);

    // Interrupt
    wr(4'h8, 32'd3);
    chk("int_idle", {31'd0, int_sig}, 32'd1);
    b = 8'($urandom);
    wr(4'h0, {24'd0, b});
    chk("int_push", {31'd0, int_sig}, 32'd0);
    wait_low("int", 1);
    frame("int", b, 3, 1'b0, -1);
    chk("int_stop", {31'd0, int_sig}, 32'd0);
    cyc();
    chk("int_done", {31'd0, int_sig}, 32'd1);
    wr(4'h8, 32'd1);
    chk("int_masked", {31'd0, int_sig}, 32'd0);

    // Clear en mid-frame
    wr(4'h8, 32'd0);
    wr(4'hC, 32'd2);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      wr(4'h0, {24'd0, b});
      exp_q.push_back(b);
    end
    wr(4'h8, 32'd1);
    wait_low("enclr", 1);
    b = exp_q.pop_front();
    frame("enclr", b, 2, 1'b0, 5);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tx !== 1'b1) held = 1'b0;
    end
    chk("enclr_held_tx", {31'd0, held}, 32'd1);
    rd(4'h4, d); chk("enclr_status", d, 32'h020);
    rd(4'h8, d); chk("enclr_ctrl", d, 32'h0);
    wr(4'h8, 32'd1);
    drain("enclr_rest", 2, 1);
    cyc();
    rd(4'h4, d); chk("enclr_idle", d, 32'h004);

    // Randomized bursts
    for (int r = 0; r < 6; r++) begin
      div = $urandom_range(1, 5);
      k   = $urandom_range(1, DEPTH);
      wr(4'h8, 32'd0);
      wr(4'hC, 32'(div));
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        wr(4'h0, {24'd0, b});
        exp_q.push_back(b);
      end
      rd(4'h4, d);
      chk($sformatf("rnd%0d_status", r), d, (32'(k) << 4) | ((k == DEPTH) ? 32'h2 : 32'h0));
      wr(4'h8, 32'd1);
      drain($sformatf("rnd%0d_", r), div, 1);
      cyc();
      rd(4'h4, d); chk($sformatf("rnd%0d_idle", r), d, 32'h004);
    end

    // DIV of zero behaves as one cycle per bit
    wr(4'hC, 32'd0);
    b = 8'($urandom);
    wr(4'h0, {24'd0, b});
    wait_low("div0", 1);
    frame("div0", b, 1, 1'b0, -1);
    cyc();

`ifdef UART_TX_PARITY_EN
    wr(4'hC, 32'd3);
    wr(4'h8, 32'd5);
    rd(4'h8, d); chk("par_ctrl", d, 32'h5);
    wr(4'h0, 32'h07);
    wait_low("par07", 1);
    frame("par07", 8'h07, 3, 1'b1, -1);
    cyc();
    wr(4'h0, 32'h03);
    wait_low("par03", 1);
    frame("par03", 8'h03, 3, 1'b1, -1);
    cyc();
`else
    wr(4'h8, 32'd7);
    rd(4'h8, d); chk("nopar_ctrl", d, 32'h3);
`endif

    // Asynchronous reset during DATA
    wr(4'hC, 32'd3);
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h5A);
    wait_low("rst_mid", 1);
    for (int i = 0; i < 5; i++) cyc();
    chk("rst_mid_pre_tx", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_int", {31'd0, int_sig}, 32'd0);
    rd(4'h4, d); chk("rst_mid_status", d, 32'h004);
    rd(4'h8, d); chk("rst_mid_ctrl", d, 32'h0);
    rd(4'hC, d); chk("rst_mid_div", d, 32'd10);
    cyc();
    rst = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (tx !== 1'b1) held = 1'b0;
    end
    chk("rst_mid_quiet", {31'd0, held}, 32'd1);
    rd(4'h4, d); chk("rst_mid_after", d, 32'h004);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
